// File: rtl/data_sram_slave_pkg.sv
// Shared constants and types for the data-SRAM responder: RAM latency, LFSR
// seed/taps, access-size encodings and the response-pipeline tag.
package data_sram_slave_pkg;

  localparam int          RAM_LAT   = 1;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16/14/13/11 of a right-shifting Fibonacci LFSR sit at bits 0/2/3/5.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2
  } size_e;

  typedef struct packed {
    logic rd;
    logic oob;
  } resp_tag_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/data_sram_slave_resp_pipe.sv
// LAT-deep response delay line: stage 1 resolves RAM read data against its tag,
// later stages shift it; the output word holds between completions.
module sram_resp_pipe
  import data_sram_slave_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  input  resp_tag_t   in_tag,
  input  logic [31:0] ram_rdata,
  output logic        out_valid,
  output logic [31:0] out_data
);

  logic [LAT-1:0] vld_q;
  resp_tag_t      tag_q;
  logic [31:0]    cap_data;
  logic [31:0]    last_data;
  logic [31:0]    hold_q;

  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn) vld_q <= '0;
    else       vld_q <= LAT'({vld_q, in_valid});
  end

  // NOTE: tag and data registers carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    tag_q <= in_tag;
  end

  assign cap_data = (tag_q.rd && !tag_q.oob) ? ram_rdata : '0;

  if (LAT == RAM_LAT) begin : g_direct
    assign last_data = cap_data;
  end else begin : g_shift
    logic [31:0] dat_q [LAT-RAM_LAT];
    always_ff @(posedge clk) begin
      dat_q[0] <= cap_data;
      for (int i = 1; i < LAT - RAM_LAT; i++) dat_q[i] <= dat_q[i-1];
    end
    assign last_data = dat_q[LAT-RAM_LAT-1];
  end

  always_ff @(posedge clk) begin
    if (!rstn)          hold_q <= '0;
    else if (out_valid) hold_q <= last_data;
  end

  assign out_valid = vld_q[LAT-1];
  assign out_data  = out_valid ? last_data : hold_q;

endmodule

// File: rtl/data_sram_slave.sv
// Responder for the core's data-SRAM req/addr_ok/data_ok protocol: decodes the
// region, drives a 1-cycle block-RAM port and returns in-order completions.
module data_sram_slave
  import data_sram_slave_pkg::*;
#(
  parameter int          ADDR_W   = 16,
  parameter logic [31:0] BASE     = 32'h0000_0000,
  parameter int          RESP_LAT = 1,
  parameter int          MAX_OS   = 2,
  parameter int          STALL_EN = 0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              data_sram_req,
  input  logic              data_sram_wr,
  input  logic [1:0]        data_sram_size,
  input  logic [3:0]        data_sram_wstrb,
  input  logic [31:0]       data_sram_addr,
  input  logic [31:0]       data_sram_wdata,
  output logic              data_sram_addr_ok,
  output logic              data_sram_data_ok,
  output logic [31:0]       data_sram_rdata,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam int CNT_W = $clog2(MAX_OS + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [15:0]      lfsr_q;
  logic             oob;
  logic             room;
  logic             stall_now;
  logic             hs;
  logic             unused_ok;

  // Size and byte offset are already resolved by the initiator.
  assign unused_ok = ^{data_sram_size, data_sram_addr[1:0]};

  assign oob       = data_sram_addr[31:ADDR_W+2] != BASE[31:ADDR_W+2];
  // A completion this cycle frees its slot for a same-cycle acceptance.
  assign room      = (cnt_q - CNT_W'(data_sram_data_ok)) < CNT_W'(MAX_OS);
  assign stall_now = (STALL_EN != 0) && (lfsr_q[1:0] == 2'b00);
  assign hs        = rstn && data_sram_req && room && !stall_now;

  assign data_sram_addr_ok = hs;
  assign ram_en            = hs && !oob;
  assign ram_we            = (hs && data_sram_wr && !oob) ? data_sram_wstrb : 4'b0000;
  assign ram_addr          = data_sram_addr[ADDR_W+1:2];
  assign ram_wdata         = data_sram_wdata;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q  <= '0;
      lfsr_q <= LFSR_SEED;
    end else begin
      cnt_q  <= cnt_q + CNT_W'(hs) - CNT_W'(data_sram_data_ok);
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  sram_resp_pipe #(
    .LAT (RESP_LAT)
  ) u_resp_pipe (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (hs),
    .in_tag    ('{rd: !data_sram_wr, oob: oob}),
    .ram_rdata (ram_rdata),
    .out_valid (data_sram_data_ok),
    .out_data  (data_sram_rdata)
  );

endmodule

// File: tb/tb_data_sram_slave.sv
// Bench for data_sram_slave: three configurations, a write-first RAM model and a
// queue-based reference model checking every cycle, plus directed sequences.
module tb_data_sram_slave;

  localparam logic [31:0] BASE = 32'h1C00_0000;
  localparam int          N    = 3;

  function automatic int lat_of(input int k);
    return k + 1;
  endfunction
  function automatic int maxos_of(input int k);
    return (k == 0) ? 2 : (k == 1) ? 1 : 4;
  endfunction
  function automatic bit stall_of(input int k);
    return k == 2;
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn      [N];
  logic        req       [N];
  logic        wr        [N];
  logic [1:0]  size      [N];
  logic [3:0]  wstrb     [N];
  logic [31:0] addr      [N];
  logic [31:0] wdata     [N];
  logic        aok       [N];
  logic        dok       [N];
  logic [31:0] rdata     [N];
  logic        ram_en    [N];
  logic [3:0]  ram_we    [N];
  logic [15:0] ram_addr  [N];
  logic [31:0] ram_wdata [N];
  logic [31:0] ram_rdata [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    data_sram_slave #(
      .ADDR_W   (16),
      .BASE     (BASE),
      .RESP_LAT (lat_of(g)),
      .MAX_OS   (maxos_of(g)),
      .STALL_EN (stall_of(g) ? 1 : 0)
    ) u_dut (
      .clk               (clk),
      .rstn              (rstn[g]),
      .data_sram_req     (req[g]),
      .data_sram_wr      (wr[g]),
      .data_sram_size    (size[g]),
      .data_sram_wstrb   (wstrb[g]),
      .data_sram_addr    (addr[g]),
      .data_sram_wdata   (wdata[g]),
      .data_sram_addr_ok (aok[g]),
      .data_sram_data_ok (dok[g]),
      .data_sram_rdata   (rdata[g]),
      .ram_en            (ram_en[g]),
      .ram_we            (ram_we[g]),
      .ram_addr          (ram_addr[g]),
      .ram_wdata         (ram_wdata[g]),
      .ram_rdata         (ram_rdata[g])
    );
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h, expected %08h at %0t", name, got, exp, $time);
  endtask

  // Write-first block RAM, one array keyed by {dut, word index}.
  logic [31:0] mem [int unsigned];
  always @(posedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (ram_en[k]) begin
        int unsigned key;
        logic [31:0] cur;
        key = (k << 16) | ram_addr[k];
        cur = mem.exists(key) ? mem[key] : 32'h0;
        for (int b = 0; b < 4; b++)
          if (ram_we[k][b]) cur[8*b +: 8] = ram_wdata[k][8*b +: 8];
        mem[key] = cur;
        ram_rdata[k] <= cur;
      end
    end
  end

  // Reference model: shadow memory updated at acceptance, queue of due responses.
  typedef struct {
    int          due;
    logic [31:0] data;
  } resp_t;

  resp_t       exp_q  [N][$];
  logic [31:0] shadow [int unsigned];
  logic [31:0] hold_m [N];
  int          lfsr_m [N];
  bit          m_init [N];
  int          aok_cnt    [N];
  int          dok_cnt    [N];
  int          stall_seen [N];
  int          cyc = 0;

  always @(posedge clk) cyc++;

  function automatic bit is_oob(input logic [31:0] a);
    return (a >> 18) != (BASE >> 18);
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      bit          due, hs, oob, stall;
      int unsigned key;
      logic [31:0] word, exp_d;
      resp_t       r;
      string       p;
      p     = $sformatf("dut%0d ", k);
      due   = (exp_q[k].size() > 0) && (exp_q[k][0].due == cyc);
      exp_d = due ? exp_q[k][0].data : hold_m[k];
      if (m_init[k]) begin
        check({p, "data_ok"}, 32'(dok[k]), 32'(due));
        check({p, "rdata"}, rdata[k], exp_d);
      end
      stall = stall_of(k) && ((lfsr_m[k] % 4) == 0);
      hs    = rstn[k] && req[k] && !stall &&
              ((exp_q[k].size() - int'(due)) < maxos_of(k));
      if (rstn[k] && req[k] && stall) stall_seen[k]++;
      check({p, "addr_ok"}, 32'(aok[k]), 32'(hs));
      if (hs) begin
        oob = is_oob(addr[k]);
        check({p, "ram_en"}, 32'(ram_en[k]), 32'(!oob));
        check({p, "ram_we"}, 32'(ram_we[k]), (wr[k] && !oob) ? 32'(wstrb[k]) : 32'h0);
        check({p, "ram_addr"}, 32'(ram_addr[k]), (addr[k] >> 2) & 32'hFFFF);
        check({p, "ram_wdata"}, ram_wdata[k], wdata[k]);
        key  = (k << 16) | ((addr[k] >> 2) & 32'hFFFF);
        word = shadow.exists(key) ? shadow[key] : 32'h0;
        if (wr[k] && !oob) begin
          for (int b = 0; b < 4; b++)
            if (wstrb[k][b]) word[8*b +: 8] = wdata[k][8*b +: 8];
          shadow[key] = word;
        end
        r.due  = cyc + lat_of(k);
        r.data = (wr[k] || oob) ? 32'h0 : word;
        exp_q[k].push_back(r);
        aok_cnt[k]++;
      end else begin
        check({p, "ram_en idle"}, 32'(ram_en[k]), 32'h0);
        check({p, "ram_we idle"}, 32'(ram_we[k]), 32'h0);
      end
      if (!rstn[k]) begin
        exp_q[k].delete();
        hold_m[k] = 32'h0;
        lfsr_m[k] = 32'hACE1;
        m_init[k] = 1'b1;
      end else begin
        if (due) begin
          hold_m[k] = exp_q[k][0].data;
          void'(exp_q[k].pop_front());
        end
        if (dok[k]) dok_cnt[k]++;
        lfsr_m[k] = (lfsr_m[k] >> 1) |
                    ((((lfsr_m[k]) ^ (lfsr_m[k] >> 2) ^ (lfsr_m[k] >> 3) ^ (lfsr_m[k] >> 5)) & 1) << 15);
      end
    end
  end

  task automatic send(input int k, input logic w, input logic [31:0] a,
                      input logic [3:0] s, input logic [31:0] d);
    bit ok;
    ok = 1'b0;
    req[k] = 1'b1; wr[k] = w; addr[k] = a; wstrb[k] = s; wdata[k] = d; size[k] = 2'd2;
    for (int c = 0; c < 64 && !ok; c++) begin
      @(negedge clk);
      ok = aok[k];
      @(posedge clk); #1;
    end
    req[k] = 1'b0; wr[k] = 1'($urandom); addr[k] = $urandom; wstrb[k] = 4'($urandom); wdata[k] = $urandom;
    check($sformatf("dut%0d accept within bound", k), 32'(ok), 32'h1);
  endtask

  task automatic wait_resp(input int k, output logic [31:0] rd, output int waited);
    bit got;
    got = 1'b0; waited = 0; rd = '0;
    for (int c = 0; c < 64 && !got; c++) begin
      @(negedge clk);
      if (dok[k]) begin
        got = 1'b1;
        rd  = rdata[k];
      end else begin
        waited++;
      end
      @(posedge clk); #1;
    end
    check($sformatf("dut%0d data_ok within bound", k), 32'(got), 32'h1);
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs [16];
  logic [31:0] rd;
  int          waited;
  int          a0, d0;
  bit          taken;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b1, BASE | 32'h10,    4'hF, 32'hDEAD_BEEF, 32'h0};
    vecs[1]  = '{1'b0, BASE | 32'h10,    4'h0, 32'h0,         32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, BASE | 32'h10,    4'hF, 32'h1122_3344, 32'h0};
    vecs[3]  = '{1'b1, BASE | 32'h12,    4'h4, 32'h5A5A_5A5A, 32'h0};
    vecs[4]  = '{1'b0, BASE | 32'h13,    4'h0, 32'h0,         32'h115A_3344};
    vecs[5]  = '{1'b1, BASE | 32'h40,    4'hF, 32'h1234_5678, 32'h0};
    vecs[6]  = '{1'b0, 32'h0000_0040,    4'h0, 32'h0,         32'h0};
    vecs[7]  = '{1'b1, 32'h0000_0040,    4'hF, 32'hCAFE_F00D, 32'h0};
    vecs[8]  = '{1'b0, BASE | 32'h40,    4'h0, 32'h0,         32'h1234_5678};
    vecs[9]  = '{1'b1, BASE | 32'h40,    4'h0, 32'hFFFF_FFFF, 32'h0};
    vecs[10] = '{1'b0, BASE | 32'h40,    4'h0, 32'h0,         32'h1234_5678};
    vecs[11] = '{1'b1, BASE | 32'h46,    4'h3, 32'hBEEF_BEEF, 32'h0};
    vecs[12] = '{1'b0, BASE | 32'h44,    4'h0, 32'h0,         32'h0000_BEEF};
    vecs[13] = '{1'b1, BASE | 32'h3FFFC, 4'hF, 32'h1357_9BDF, 32'h0};
    vecs[14] = '{1'b0, BASE | 32'h3FFFC, 4'h0, 32'h0,         32'h1357_9BDF};
    vecs[15] = '{1'b0, 32'h1C04_0000,    4'h0, 32'h0,         32'h0};

    for (int k = 0; k < N; k++) begin
      rstn[k] = 1'b0; req[k] = 1'b1; wr[k] = 1'b0; size[k] = 2'd2; wstrb[k] = 4'hF;
      addr[k] = BASE | 32'h10; wdata[k] = 32'h0; hold_m[k] = 32'h0; lfsr_m[k] = 32'hACE1;
      m_init[k] = 1'b0; aok_cnt[k] = 0; dok_cnt[k] = 0; stall_seen[k] = 0;
    end

    // Reset with requests pending: nothing may be accepted or completed.
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      check($sformatf("dut%0d reset addr_ok", k), 32'(aok[k]), 32'h0);
      check($sformatf("dut%0d reset data_ok", k), 32'(dok[k]), 32'h0);
      check($sformatf("dut%0d reset rdata", k), rdata[k], 32'h0);
      check($sformatf("dut%0d reset ram_en", k), 32'(ram_en[k]), 32'h0);
      check($sformatf("dut%0d reset ram_we", k), 32'(ram_we[k]), 32'h0);
    end
    @(posedge clk); #1;
    for (int k = 0; k < N; k++) begin rstn[k] = 1'b1; req[k] = 1'b0; end

    // Vector table on the RESP_LAT=1 instance.
    for (int i = 0; i < 16; i++) begin
      send(0, vecs[i].wr, vecs[i].addr, vecs[i].wstrb, vecs[i].wdata);
      wait_resp(0, rd, waited);
      check($sformatf("vec%0d rdata", i), rd, vecs[i].exp);
      check($sformatf("vec%0d latency", i), 32'(waited), 32'(lat_of(0) - 1));
    end

    // Back-to-back write then read of the same word must see the new data.
    req[0] = 1'b1; wr[0] = 1'b1; addr[0] = BASE | 32'h80; wstrb[0] = 4'hF; wdata[0] = 32'hA5A5_A5A5;
    @(negedge clk);
    check("raw write accepted", 32'(aok[0]), 32'h1);
    @(posedge clk); #1;
    wr[0] = 1'b0; wdata[0] = 32'h0;
    @(negedge clk);
    check("raw read accepted", 32'(aok[0]), 32'h1);
    check("raw write data_ok", 32'(dok[0]), 32'h1);
    @(posedge clk); #1;
    req[0] = 1'b0;
    @(negedge clk);
    check("raw read data_ok", 32'(dok[0]), 32'h1);
    check("raw read rdata", rdata[0], 32'hA5A5_A5A5);
    @(posedge clk); #1;

    // MAX_OS=1, RESP_LAT=2 with request held: one acceptance every 2 cycles.
    send(1, 1'b1, BASE | 32'h10, 4'hF, 32'h7766_5544);
    wait_resp(1, rd, waited);
    a0 = aok_cnt[1]; d0 = dok_cnt[1];
    req[1] = 1'b1; wr[1] = 1'b0; addr[1] = BASE | 32'h10;
    repeat (20) begin @(posedge clk); #1; end
    req[1] = 1'b0;
    check("os-limit accepts in 20 cycles", 32'(aok_cnt[1] - a0), 32'd10);
    repeat (5) begin @(posedge clk); #1; end
    check("os-limit completions equal accepts", 32'(dok_cnt[1] - d0), 32'(aok_cnt[1] - a0));

    // Random traffic with LFSR stalls on the RESP_LAT=3 instance.
    taken = 1'b1;
    for (int c = 0; c < 240; c++) begin
      if (taken) begin
        if ($urandom_range(0, 4) != 0) begin
          req[2] = 1'b1; wr[2] = 1'($urandom); wstrb[2] = 4'($urandom);
          wdata[2] = $urandom; size[2] = 2'($urandom);
          addr[2] = ($urandom_range(0, 7) == 0) ? ($urandom & 32'h0003_FFFF)
                  : (BASE | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3)));
        end else begin
          req[2] = 1'b0; addr[2] = $urandom; wdata[2] = $urandom;
        end
      end
      @(negedge clk);
      taken = !req[2] || aok[2];
      @(posedge clk); #1;
    end
    req[2] = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
    check("stall cycles exercised", 32'(stall_seen[2] > 0), 32'h1);
    check("random completions equal accepts", 32'(dok_cnt[2]), 32'(aok_cnt[2]));

    // Reset one cycle after a read handshake: in-flight responses vanish.
    send(2, 1'b1, BASE | 32'h20, 4'hF, 32'h0BAD_CAFE);
    wait_resp(2, rd, waited);
    send(2, 1'b1, BASE | 32'h24, 4'hF, 32'h600D_F00D);
    send(2, 1'b0, BASE | 32'h20, 4'h0, 32'h0);
    rstn[2] = 1'b0; req[2] = 1'b1; addr[2] = BASE | 32'h28;
    @(negedge clk);
    check("mid-reset addr_ok", 32'(aok[2]), 32'h0);
    @(posedge clk); #1;
    rstn[2] = 1'b1; req[2] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("post-reset data_ok c%0d", c), 32'(dok[2]), 32'h0);
      @(posedge clk); #1;
    end
    send(2, 1'b0, BASE | 32'h24, 4'h0, 32'h0);
    wait_resp(2, rd, waited);
    check("post-reset committed write", rd, 32'h600D_F00D);
    check("post-reset latency", 32'(waited), 32'(lat_of(2) - 1));
    send(2, 1'b0, BASE | 32'h20, 4'h0, 32'h0);
    wait_resp(2, rd, waited);
    check("post-reset read", rd, 32'h0BAD_CAFE);

    repeat (2) begin @(posedge clk); #1; end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
